// File: rtl/tdc_meas_sequencer_if.sv
// tdc_meas_sequencer_if: control/status bundle between the TDC measurement sequencer and its engines
interface tdc_meas_sequencer_if;
  logic       enable;
  logic [7:0] n_meas;
  logic       start_cfg;
  logic       end_cfg;
  logic       intb_n;
  logic       start_read;
  logic       end_read;
  logic       spi_owner;
  logic       busy;
  logic       done;
  logic [7:0] meas_count;
  logic       timeout_err;
  modport master (
    output enable, n_meas, end_cfg, intb_n, end_read,
    input  start_cfg, start_read, spi_owner, busy, done, meas_count, timeout_err
  );
  modport slave (
    input  enable, n_meas, end_cfg, intb_n, end_read,
    output start_cfg, start_read, spi_owner, busy, done, meas_count, timeout_err
  );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// tdc_meas_sequencer: runs config -> wait-interrupt -> readout cycles for a TDC, with timeout and abort
module tdc_meas_sequencer #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int          SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  tdc_meas_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CFG, WAIT_CFG, WAIT_INT, READ, WAIT_READ, NEXT, DONE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [15:0] tmo_cnt;
  logic [7:0]  n_lat;
  logic [7:0]  meas_cnt;
  logic [7:0]  cnt_inc;
  logic        owner;
  logic        tmo_err;
  logic        need_low;
  logic        int_s;
  logic        tmo_hit;
  assign int_s   = ~sync[SYNC_STAGES-1];
  assign tmo_hit = tmo_cnt == TIMEOUT_CYC - 16'd1;
  assign cnt_inc = &meas_cnt ? meas_cnt : meas_cnt + 8'd1;
  // oldest sample sits in the MSB; idle-high so reset does not look like an interrupt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= '1;
    else sync <= SYNC_STAGES'({sync, bus.intb_n});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:      state_nx = bus.enable && !need_low ? CFG : IDLE;
      CFG:       state_nx = WAIT_CFG;
      WAIT_CFG:  state_nx = bus.end_cfg ? WAIT_INT : WAIT_CFG;
      WAIT_INT:  state_nx = !bus.enable ? DONE : int_s ? READ : tmo_hit ? NEXT : WAIT_INT;
      READ:      state_nx = WAIT_READ;
      WAIT_READ: state_nx = bus.end_read ? NEXT : WAIT_READ;
      NEXT:      state_nx = (n_lat != 8'd0 && cnt_inc == n_lat) || !bus.enable ? DONE : CFG;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // owner flips on entry to CFG/READ so it is already valid during the start pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmo_cnt  <= 16'd0;
      n_lat    <= 8'd0;
      meas_cnt <= 8'd0;
      owner    <= 1'b0;
      tmo_err  <= 1'b0;
      need_low <= 1'b0;
    end else begin
      tmo_cnt  <= state == WAIT_INT ? tmo_cnt + 16'd1 : 16'd0;
      owner    <= state_nx == CFG ? 1'b0 : state_nx == READ ? 1'b1 : owner;
      need_low <= state == DONE ? bus.enable : need_low && bus.enable;
      if (state == IDLE && state_nx == CFG) begin
        n_lat    <= bus.n_meas;
        meas_cnt <= 8'd0;
        tmo_err  <= 1'b0;
      end
      if (state == NEXT) meas_cnt <= cnt_inc;
      if (state == WAIT_INT && state_nx == NEXT) tmo_err <= 1'b1;
    end
  always_comb begin
    bus.start_cfg   = state == CFG;
    bus.start_read  = state == READ;
    bus.busy        = state != IDLE;
    bus.done        = state == DONE;
    bus.spi_owner   = owner;
    bus.meas_count  = meas_cnt;
    bus.timeout_err = tmo_err;
  end
endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// tb_tdc_meas_sequencer: directed and randomized campaigns checked against a per-campaign outcome model
module tb_tdc_meas_sequencer;
  localparam logic [15:0] TMO = 16'd100;
  localparam int SYN = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int vectors = 0;
  int errs = 0;
  int n_cfg = 0, n_rd = 0, n_done = 0, viol = 0;
  logic prev_cfg = 0, prev_rd = 0, prev_done = 0, prev_owner = 0, prev_ok = 0;
  tdc_meas_sequencer_if t_if();
  tdc_meas_sequencer #(.TIMEOUT_CYC(TMO), .SYNC_STAGES(SYN)) dut (
    .clk(clk), .rst_n(rst_n), .bus(t_if.slave)
  );
  always #5 clk = ~clk;
  // pulse counters and protocol watch, sampled 2 time units after each rising edge
  always begin
    @(posedge clk);
    #2;
    if (rst_n && prev_ok) begin
      if (t_if.spi_owner !== prev_owner && !t_if.start_cfg && !t_if.start_read) viol++;
      if (t_if.start_cfg && (t_if.spi_owner || prev_cfg)) viol++;
      if (t_if.start_read && (!t_if.spi_owner || prev_rd)) viol++;
      if (t_if.done && prev_done) viol++;
    end
    if (t_if.start_cfg) n_cfg++;
    if (t_if.start_read) n_rd++;
    if (t_if.done) n_done++;
    prev_cfg = t_if.start_cfg;
    prev_rd = t_if.start_read;
    prev_done = t_if.done;
    prev_owner = t_if.spi_owner;
    prev_ok = rst_n;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] outs();
    return 32'({t_if.busy, t_if.spi_owner, t_if.start_cfg, t_if.start_read, t_if.done,
                t_if.timeout_err, t_if.meas_count});
  endfunction
  task automatic wait_pulse(input int which, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = which == 0 ? t_if.start_cfg : which == 1 ? t_if.start_read : t_if.done;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask
  task automatic pulse(input int which, input int dly);
    repeat (dly) @(negedge clk);
    if (which == 0) t_if.end_cfg = 1'b1;
    else t_if.end_read = 1'b1;
    @(negedge clk);
    t_if.end_cfg = 1'b0;
    t_if.end_read = 1'b0;
  endtask
  task automatic meas(input logic to, input int dc, input int di, input int dr, input logic abort_rd);
    wait_pulse(0, 200, "start_cfg");
    pulse(0, dc);
    if (!to) begin
      repeat (di) @(negedge clk);
      t_if.intb_n = 1'b0;
      wait_pulse(1, 20, "start_read");
      t_if.intb_n = 1'b1;
      if (abort_rd) begin
        @(negedge clk);
        t_if.enable = 1'b0;
      end
      pulse(1, dr);
    end
  endtask
  task automatic campaign(input int n, input logic rnd, input logic keep_en);
    int c0, r0, d0, exp_rd;
    logic exp_to;
    c0 = n_cfg; r0 = n_rd; d0 = n_done; exp_rd = 0; exp_to = 1'b0;
    t_if.n_meas = 8'(n);
    t_if.enable = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic to;
      to = rnd && $urandom_range(0, 3) == 0;
      meas(to, rnd ? int'($urandom_range(1, 6)) : 4, rnd ? int'($urandom_range(0, 60)) : 20,
           rnd ? int'($urandom_range(1, 31)) : 30, 1'b0);
      if (i == 0) t_if.n_meas = 8'($urandom);
      if (!to) exp_rd++;
      exp_to |= to;
    end
    wait_pulse(2, 200, "done");
    chk("meas_count", 32'(t_if.meas_count), 32'(n));
    chk("timeout_err", 32'(t_if.timeout_err), 32'(exp_to));
    @(negedge clk);
    chk("cfg_pulses", n_cfg - c0, n);
    chk("read_pulses", n_rd - r0, exp_rd);
    chk("done_pulses", n_done - d0, 1);
    chk("idle_after_done", 32'(t_if.busy), 32'd0);
    if (!keep_en) begin
      t_if.enable = 1'b0;
      @(negedge clk);
    end
  endtask
  initial begin
    int c0, r0, d0;
    t_if.enable = 1'b0;
    t_if.n_meas = 8'd0;
    t_if.end_cfg = 1'b0;
    t_if.end_read = 1'b0;
    t_if.intb_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 chk("reset_state", outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // normal three-measurement campaign
    campaign(3, 1'b0, 1'b0);
    // enable held high after done must not restart
    campaign(1, 1'b0, 1'b1);
    c0 = n_cfg;
    repeat (30) @(negedge clk);
    chk("no_auto_restart", n_cfg - c0, 0);
    chk("no_restart_busy", 32'(t_if.busy), 32'd0);
    t_if.enable = 1'b0;
    @(negedge clk);
    campaign(1, 1'b0, 1'b0);
    // timeout campaign with exact decision cycle
    r0 = n_rd;
    t_if.n_meas = 8'd2;
    t_if.enable = 1'b1;
    wait_pulse(0, 20, "tmo_start_cfg");
    pulse(0, 1);
    repeat (int'(TMO) - 1) @(negedge clk);
    chk("tmo_not_yet", 32'({t_if.busy, t_if.timeout_err}), 32'b10);
    @(negedge clk);
    chk("tmo_fired", 32'(t_if.timeout_err), 32'd1);
    meas(1'b1, 3, 0, 0, 1'b0);
    wait_pulse(2, 200, "tmo_done");
    chk("tmo_meas_count", 32'(t_if.meas_count), 32'd2);
    chk("tmo_err_sticky", 32'(t_if.timeout_err), 32'd1);
    chk("tmo_no_read", n_rd - r0, 0);
    t_if.enable = 1'b0;
    @(negedge clk);
    // interrupt synchronized exactly in the timeout cycle wins
    t_if.n_meas = 8'd1;
    t_if.enable = 1'b1;
    wait_pulse(0, 20, "race_start_cfg");
    pulse(0, 1);
    repeat (int'(TMO) - SYN - 1) @(negedge clk);
    t_if.intb_n = 1'b0;
    repeat (SYN + 1) @(negedge clk);
    chk("race_read", 32'(t_if.start_read), 32'd1);
    chk("race_err_clear", 32'(t_if.timeout_err), 32'd0);
    t_if.intb_n = 1'b1;
    pulse(1, 2);
    wait_pulse(2, 20, "race_done");
    chk("race_count", 32'(t_if.meas_count), 32'd1);
    t_if.enable = 1'b0;
    @(negedge clk);
    // one cycle later the timeout wins
    r0 = n_rd;
    t_if.enable = 1'b1;
    wait_pulse(0, 20, "late_start_cfg");
    pulse(0, 1);
    repeat (int'(TMO) - SYN) @(negedge clk);
    t_if.intb_n = 1'b0;
    repeat (SYN) @(negedge clk);
    chk("late_no_read", 32'({t_if.start_read, t_if.timeout_err}), 32'b01);
    t_if.intb_n = 1'b1;
    wait_pulse(2, 20, "late_done");
    @(negedge clk);
    chk("late_read_pulses", n_rd - r0, 0);
    t_if.enable = 1'b0;
    @(negedge clk);
    // continuous campaign aborted during the fifth readout
    c0 = n_cfg; r0 = n_rd; d0 = n_done;
    t_if.n_meas = 8'd0;
    t_if.enable = 1'b1;
    for (int i = 0; i < 5; i++)
      meas(1'b0, int'($urandom_range(1, 5)), int'($urandom_range(0, 30)),
           int'($urandom_range(2, 10)), i == 4);
    wait_pulse(2, 20, "cont_done");
    chk("cont_count", 32'(t_if.meas_count), 32'd5);
    @(negedge clk);
    chk("cont_cfg", n_cfg - c0, 5);
    chk("cont_read", n_rd - r0, 5);
    chk("cont_done_pulses", n_done - d0, 1);
    // abort while waiting for the interrupt
    r0 = n_rd;
    t_if.enable = 1'b1;
    meas(1'b0, 2, 3, 2, 1'b0);
    wait_pulse(0, 20, "abort_start_cfg");
    pulse(0, 2);
    repeat (5) @(negedge clk);
    t_if.enable = 1'b0;
    @(negedge clk);
    chk("abort_wait_int", 32'({t_if.done, t_if.meas_count}), 32'h101);
    @(negedge clk);
    chk("abort_reads", n_rd - r0, 1);
    // meas_count saturates in a long continuous campaign
    c0 = n_cfg;
    t_if.enable = 1'b1;
    for (int i = 0; i < 257; i++) meas(1'b0, 1, 0, 1, i == 256);
    wait_pulse(2, 20, "sat_done");
    chk("sat_count", 32'(t_if.meas_count), 32'd255);
    @(negedge clk);
    chk("sat_cfg", n_cfg - c0, 257);
    // randomized campaigns
    repeat (8) campaign(int'($urandom_range(1, 4)), 1'b1, 1'b0);
    // asynchronous reset during WAIT_CFG, then a stray end_cfg
    t_if.n_meas = 8'd3;
    t_if.enable = 1'b1;
    meas(1'b0, 2, 5, 3, 1'b0);
    wait_pulse(0, 20, "rst_start_cfg");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", outs(), 32'd0);
    t_if.enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = n_cfg; r0 = n_rd; d0 = n_done;
    pulse(0, 1);
    repeat (10) @(negedge clk);
    chk("rst_stray_pulses", (n_cfg - c0) + (n_rd - r0) + (n_done - d0), 0);
    chk("rst_stray_busy", 32'(t_if.busy), 32'd0);
    campaign(2, 1'b0, 1'b0);
    chk("protocol", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/tdc_meas_sequencer.md
TDC_MEAS_SEQUENCER -- requirements
Module: tdc_meas_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16'd50000, is the maximum number of clk cycles to wait for the TDC interrupt per measurement.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on intb_n.
REQ-003 The block SHALL have these ports:
clk  in  1  system clock; all logic on posedge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = run measurement campaign
n_meas  in  8  measurements per campaign; 0 = continuous; sampled on campaign start
start_cfg  out  1  one-cycle pulse to the config-write engine (arms TDC, START_MEAS)
end_cfg  in  1  one-cycle pulse from the config-write engine, transfer complete
intb_n  in  1  TDC interrupt, active-low, asynchronous to clk
start_read  out  1  one-cycle pulse to the SPI read engine
end_read  in  1  one-cycle pulse from the SPI read engine, readout complete
spi_owner  out  1  SPI mux select; 0 = config engine, 1 = read engine
busy  out  1  high whenever the state is not IDLE
done  out  1  one-cycle pulse at campaign end
meas_count  out  8  completed measurements in current campaign (reads + timeouts)
timeout_err  out  1  sticky; set on any interrupt timeout, cleared at campaign start

Function
REQ-004 The FSM SHALL have states IDLE, CFG, WAIT_CFG, WAIT_INT, READ, WAIT_READ, NEXT, DONE.
REQ-005 IDLE -> CFG when enable=1; on that transition latch n_meas, clear meas_count and timeout_err.
REQ-006 CFG SHALL assert start_cfg for exactly one cycle with spi_owner=0 and go to WAIT_CFG.
REQ-007 WAIT_CFG SHALL hold spi_owner=0 until end_cfg=1, then go to WAIT_INT, clearing the timeout counter.
REQ-008 intb_n SHALL pass through SYNC_STAGES flops; WAIT_INT SHALL react only to the synchronized falling level (sync=0).
REQ-009 WAIT_INT -> READ when the synchronized intb_n is 0; otherwise the timeout counter increments each cycle.
REQ-010 When the counter reaches TIMEOUT_CYC-1 with no interrupt, WAIT_INT SHALL set timeout_err and go to NEXT without issuing a read.
REQ-011 An interrupt arriving in the same cycle as the timeout SHALL win: go to READ, and leave timeout_err unchanged.
REQ-012 READ SHALL switch spi_owner to 1, and in the same cycle pulse start_read once; it then goes to WAIT_READ.
REQ-013 WAIT_READ SHALL hold spi_owner=1 until end_read=1, then go to NEXT.
REQ-014 spi_owner SHALL change only in CFG (to 0) and READ (to 1), never while a transfer is in flight.
REQ-015 NEXT SHALL increment meas_count by 1, saturating at 8'hFF.
REQ-016 From NEXT: if the latched n_meas != 0 and the incremented count equals n_meas, go to DONE.
REQ-017 From NEXT: otherwise, if enable=0, go to DONE; otherwise go to CFG.
REQ-018 With latched n_meas=0, the campaign SHALL run until enable=0 is seen in NEXT.
REQ-019 enable=0 in CFG, WAIT_CFG, READ or WAIT_READ SHALL NOT abort the state; the abort takes effect at the next NEXT.
REQ-020 enable=0 in WAIT_INT SHALL go directly to DONE without incrementing meas_count.
REQ-021 DONE SHALL pulse done for one cycle and return to IDLE.
REQ-022 DONE SHALL hold IDLE until enable is seen low for at least one cycle, so there is no auto-restart while enable stays high.
REQ-023 end_cfg and end_read pulses arriving in any state other than their WAIT state SHALL be ignored.
REQ-024 Undefined state encodings SHALL recover to IDLE on the next clk.

Reset
REQ-025 On rst_n=0, asynchronously: state=IDLE, start_cfg=0, start_read=0, spi_owner=0, busy=0, done=0, meas_count=0, timeout_err=0, timeout counter=0, synchronizer flops=1.
REQ-026 Reset asserted mid-transfer SHALL abort immediately with the same values; no pulse is issued after release until enable is sampled high in IDLE.

Verification
REQ-027 Normal run: n_meas=3, enable=1; end_cfg 4 cycles after each start_cfg, intb_n low 20 cycles later, end_read 30 cycles after start_read -> three start_cfg/start_read pairs, meas_count=3, one done pulse, timeout_err=0.
REQ-028 Timeout: TIMEOUT_CYC=100, n_meas=2, intb_n held high -> no start_read, timeout_err=1, meas_count=2, done asserted.
REQ-029 Race: intb_n synchronized low in exactly the timeout cycle -> start_read issued, timeout_err stays 0.
REQ-030 Continuous with abort: n_meas=0; drop enable during WAIT_READ of measurement 5 -> read completes, meas_count=5, done pulse, IDLE.
REQ-031 Abort in WAIT_INT: drop enable while waiting -> DONE next cycle, meas_count unchanged, no start_read.
REQ-032 Reset mid-run: rst_n low during WAIT_CFG -> all outputs at reset values the same cycle; a stray end_cfg after release is ignored.
